// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: default sizing, control states
// and the lane keep-mask helper.
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_LANES = 4;

    typedef enum logic {
        FILL,
        OUT
    } state_e;

    // Mask with the low cnt bits set; callers truncate to their lane count.
    function automatic logic [31:0] keep_from_count(input int unsigned cnt);
        return (32'd1 << cnt) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_read_packer.sv
// Pops WIDTH-bit FIFO entries and packs LANES of them little-endian into one word,
// presented on a valid/ready output; a flush closes out a partial word.
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LANES = DEFAULT_LANES,
    parameter int unsigned OUT_W = WIDTH * LANES
) (
    input  logic             rd_clk,
    input  logic             reset,
    input  logic             empty,
    input  logic [WIDTH-1:0] read_data,
    output logic             read_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [LANES-1:0] out_keep,
    output logic             out_last
);

    localparam int unsigned CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W:0]   LANES_C   = (CNT_W + 1)'(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_lane_cnt, w_lane_cnt_nxt;
    logic               r_pending, w_pending_nxt;
    logic               r_flush_req, w_flush_req_nxt;
    logic [OUT_W-1:0]   r_data, w_data_nxt;
    logic [LANES-1:0]   r_keep, w_keep_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W:0]     w_fill_sum;
    logic               w_pop;

    // Lanes already captured plus the one in flight must leave room for another pop.
    assign w_fill_sum = {1'b0, r_lane_cnt} + {{CNT_W{1'b0}}, r_pending};
    assign read_en    = (r_state == FILL) && !empty && !r_flush_req && (w_fill_sum < LANES_C);
    assign w_pop      = read_en && !empty;

    assign out_valid = (r_state == OUT);
    assign out_data  = r_data;
    assign out_keep  = r_keep;
    assign out_last  = r_last;

    always_comb begin
        w_state_nxt     = r_state;
        w_lane_cnt_nxt  = r_lane_cnt;
        w_pending_nxt   = w_pop;
        w_flush_req_nxt = r_flush_req;
        w_data_nxt      = r_data;
        w_keep_nxt      = r_keep;
        w_last_nxt      = r_last;
        unique case (r_state)
            FILL: begin
                if (flush) begin
                    w_flush_req_nxt = 1'b1;
                end
                if (r_pending) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (r_lane_cnt == CNT_W'(i)) begin
                            w_data_nxt[i*WIDTH +: WIDTH] = read_data;
                        end
                    end
                    w_lane_cnt_nxt = r_lane_cnt + CNT_W'(1);
                    if (r_lane_cnt == LAST_LANE) begin
                        w_state_nxt     = OUT;
                        w_keep_nxt      = '1;
                        w_last_nxt      = r_flush_req | flush;
                        w_flush_req_nxt = 1'b0;
                    end
                end else if (r_flush_req) begin
                    // Nothing in flight: close the partial word, or drop the flush if empty.
                    w_flush_req_nxt = 1'b0;
                    if (r_lane_cnt != '0) begin
                        w_state_nxt = OUT;
                        w_keep_nxt  = LANES'(keep_from_count(32'(r_lane_cnt)));
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_state_nxt    = FILL;
                    w_lane_cnt_nxt = '0;
                    w_data_nxt     = '0;
                    w_keep_nxt     = '0;
                    w_last_nxt     = 1'b0;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FILL;
            r_lane_cnt  <= '0;
            r_pending   <= 1'b0;
            r_flush_req <= 1'b0;
            r_data      <= '0;
            r_keep      <= '0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane_cnt  <= w_lane_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_flush_req <= w_flush_req_nxt;
            r_data      <= w_data_nxt;
            r_keep      <= w_keep_nxt;
            r_last      <= w_last_nxt;
        end
    end

endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Read-side consumer of asynchronous_fifo, clocked in the FIFO read domain.
- Pops WIDTH-bit entries from the FIFO and packs LANES consecutive entries into one wide word, little-endian (first entry in LSBs).
- Presents the packed word on a valid/ready output.
- A flush request closes out a partial word, marked with a lane keep mask and a last flag.

Parameters:
- WIDTH, 8, FIFO entry width; must match the FIFO's WIDTH.
- LANES, 4, entries per packed word; must be at least 2.
- OUT_W, WIDTH*LANES, packed word width; derived, never overridden.

Ports:
- rd_clk  input  1  read-domain clock, shared with the FIFO read side.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- empty  input  1  FIFO empty flag.
- read_data  input  WIDTH  FIFO read data; valid on the cycle after a pop.
- read_en  output  1  FIFO pop request.
- flush  input  1  single-cycle pulse: emit the partial word.
- out_valid  output  1  packed word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  OUT_W  packed word; lane i is bits [i*WIDTH +: WIDTH].
- out_keep  output  LANES  bit i set means lane i holds data.
- out_last  output  1  word was closed by a flush.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FILL; lane_cnt=0; pending=0; flush_req=0; data register cleared.
  - Outputs: out_valid=0, out_data=0, out_keep=0, out_last=0, read_en=0.
- Pop definition: pop = read_en && !empty at a rising edge of rd_clk.
- FIFO read latency is exactly one cycle: read_data is captured on the edge after the pop.
- read_en is combinational and asserted only when all of the following hold:
  - state==FILL,
  - !empty,
  - !flush_req,
  - lane_cnt + pending < LANES.
- Capture:
  - If pending=1 at an edge, read_data is written to lane lane_cnt and lane_cnt increments.
  - pending is then set to the value of pop at that same edge.
- FILL→OUT, full word:
  - Taken at the capture edge where lane_cnt becomes LANES.
  - out_keep = all ones.
  - out_last = flush_req; flush_req is then cleared.
- FILL→OUT, flush:
  - Taken when flush_req=1, pending=0 and 0 < lane_cnt < LANES.
  - out_keep = (1<<lane_cnt)-1; unfilled lanes are 0; out_last=1; flush_req is cleared.
- flush with lane_cnt=0 and pending=0 is dropped: no output, flush_req cleared.
- flush sampled in FILL sets flush_req. flush sampled in OUT is ignored.
- OUT state:
  - out_valid=1; out_data, out_keep and out_last are held stable; read_en=0.
  - On out_valid && out_ready: clear lanes, lane_cnt=0, out_valid=0, keep=0, last=0, state→FILL.
- Latency and throughput with empty held at 0 and out_ready held at 1:
  - First pop at edge E0; out_valid rises after E4 (LANES+1 edges).
  - Handshake at E5; next pop at E6.
  - Steady state is one word per LANES+2 cycles.
- empty toggling between pops only stalls read_en; lane order is preserved.
- Back-pressure (out_ready=0 in OUT): the word is held indefinitely and no pops occur.
- Reset asserted mid-word discards captured lanes and any pending entry. The FIFO is reset by the same event.
- lane_cnt is sized as $clog2(LANES+1) bits and never exceeds LANES.

Decomposition:
- Shared package fifo_pkg holds:
  - default WIDTH and LANES,
  - the state enum {FILL, OUT},
  - a keep-mask function keep_from_count(cnt).
- No sub-module: the datapath (lane register plus demux write) and the two-state control fit in a single module.

Test Plan:
- Push 01,02,03,04 into the FIFO; out_ready=1 → one word, out_data=0x04030201, out_keep=4'b1111, out_last=0; read_en low during OUT.
- Push AA,BB, then pulse flush after both are captured → out_data=0x0000BBAA, out_keep=4'b0011, out_last=1.
- Push 8 entries 10..17 and hold out_ready=0 for 10 cycles in OUT:
  - out_data=0x13121110 stays stable; read_en=0 throughout.
  - After release, the second word is 0x17161514.
- Toggle empty each cycle while pushing 21..24 → out_data=0x24232221; no duplicated or skipped lanes.
- Pulse flush with lane_cnt=0 → no out_valid. Pulse flush during OUT → ignored, out_last stays 0.
- Drive reset=0 after 2 of 4 captures → all outputs 0 immediately. After release, push 31..34 → out_data=0x34333231, keep=4'b1111.
